div_unit: RTL and testbench

Iterative 32-bit integer divider for the datapath's HI/LO register pair, the counterpart to the multiplier. On a start pulse it captures dividend `a` and divisor `b` and runs a restoring shift-subtract loop, one quotient bit per clock. It then writes the quotient to `lo` and the remainder to `hi`, as MIPS `div`/`divu` require. The control unit pulses `comeco` and stalls until `pronto`.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 172 +++++++++++++++++
 tb/tb_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative HI/LO divider: FSM state encoding,
// default operand width and the iteration counter width.
package div_pkg;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    INICIAL   = 2'd1,
    REPETICAO = 2'd2,
    FIM       = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
// The partial remainder is one bit wider than the operands so the sign of the
// trial subtraction can be read from its MSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;

  // Shift {R,Q} left, try subtracting the divisor, keep the result if non-negative.
  always_comb begin
    {r_sh, q_sh} = {r_in, q_in} << 1;
    t            = r_sh - {1'b0, d_in};
    if (!t[WIDTH]) begin
      r_out = t;
      q_out = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_out = r_sh;
      q_out = q_sh;
    end
  end

endmodule : div_step

// File: rtl/div_unit.sv
// Iterative integer divider writing quotient to LO and remainder to HI.
// One quotient bit per clock; a divide by zero finishes right after capture
// with div_zero set and HI/LO untouched.
// Optional feature: define DIV_SIGNED_EN for two's-complement div, otherwise
// the unit performs unsigned divu only.
//
// state     | meaning
// ----------+----------------------------------------------
// ESPERA    | idle, waiting for comeco
// INICIAL   | capture operand magnitudes, clear working regs
// REPETICAO | one shift-subtract step per clock, WIDTH steps
// FIM       | write hi/lo (or flag divide by zero), pulse pronto
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             comeco,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ocupado,
  output logic             pronto,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             pronto_q, pronto_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  // Next-state and datapath update for the divide sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pronto_d   = 1'b0;
    div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
`endif

    case (state_q)
      ESPERA: begin
        if (comeco) state_d = INICIAL;
      end

      INICIAL: begin
`ifdef DIV_SIGNED_EN
        d_d       = magnitude(b);
        q_d       = magnitude(a);
        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
        neg_rem_d = a[WIDTH-1];
`else
        d_d       = b;
        q_d       = a;
`endif
        r_d        = '0;
        cnt_d      = '0;
        div_zero_d = 1'b0;
        state_d    = (b == '0) ? FIM : REPETICAO;
      end

      REPETICAO: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIM;
      end

      FIM: begin
        state_d  = ESPERA;
        pronto_d = 1'b1;
        // |b| is zero exactly when b was zero, so the divisor register
        // doubles as the divide-by-zero marker.
        if (d_q == '0) begin
          div_zero_d = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          lo_d = neg_quo_q ? negate(q_q) : q_q;
          hi_d = neg_rem_q ? negate(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
`else
          lo_d = q_q;
          hi_d = r_q[WIDTH-1:0];
`endif
        end
      end

      default: state_d = ESPERA;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ESPERA;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pronto_q   <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pronto_q   <= pronto_d;
      div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign pronto   = pronto_q;
  assign div_zero = div_zero_q;
  assign ocupado  = (state_q != ESPERA);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divides with hand-computed results,
// then divide-by-zero, mid-operation reset and busy/back-to-back sequences.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        comeco;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ocupado;
  logic        pronto;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[6];

  div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .comeco   (comeco),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Start a divide and return the edge number (after edge 0) at which pronto
  // is first seen; -1 if it never appears. Operands are scrambled after
  // edge 2 to show they were captured at edge 1.
  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, output int lat);
    @(negedge clock);
    a = ta; b = tb_v; comeco = 1'b1;
    @(posedge clock); #1;
    comeco = 1'b0;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock); #1;
      if (e == 2) begin
        a = ~ta;
        b = tb_v ^ 32'h5;
      end
      if (pronto) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int npr;
    int pr_edge[2];
    logic [31:0] lo2, hi2;
    logic [31:0] keep_lo, keep_hi;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[2] = '{32'd100,       32'd7,        32'd14,        32'd2};
    vecs[3] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[4] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};
    vecs[5] = '{32'd5,         32'd9,        32'd0,         32'd5};
`else
    vecs[0] = '{32'd100,       32'd7,        32'd14,        32'd2};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[2] = '{32'd5,         32'd9,        32'd0,         32'd5};
    vecs[3] = '{32'h1234_5678, 32'h0000_0100, 32'h0012_3456, 32'h78};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[5] = '{32'h8000_0000, 32'd3,        32'h2AAA_AAAA, 32'd2};
`endif

    reset = 1'b1; comeco = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_ocupado", {31'd0, ocupado}, 32'd0);
    check("reset_pronto", {31'd0, pronto}, 32'd0);
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd34);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_div_zero", i), {31'd0, div_zero}, 32'd0);
      check($sformatf("vec%0d_ocupado", i), {31'd0, ocupado}, 32'd0);
      @(posedge clock); #1;
      check($sformatf("vec%0d_pronto_pulse", i), {31'd0, pronto}, 32'd0);
    end

    // Divide by zero keeps the previous results.
    keep_lo = vecs[5].lo;
    keep_hi = vecs[5].hi;
    run_div(32'd42, 32'd0, lat);
    check("dz_latency", lat, 32'd2);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_lo_kept", lo, keep_lo);
    check("dz_hi_kept", hi, keep_hi);
    @(posedge clock); #1;
    check("dz_pronto_pulse", {31'd0, pronto}, 32'd0);
    run_div(32'd100, 32'd7, lat);
    check("after_dz_flag_clear", {31'd0, div_zero}, 32'd0);
    check("after_dz_lo", lo, 32'd14);

    // Reset sampled at edge 10 of an operation.
    @(negedge clock);
    a = 32'd63; b = 32'd5; comeco = 1'b1;
    @(posedge clock); #1;
    comeco = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_ocupado", {31'd0, ocupado}, 32'd0);
    check("midrst_pronto", {31'd0, pronto}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    npr = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      if (pronto) npr++;
    end
    check("midrst_no_pronto", npr, 32'd0);
    run_div(32'd100, 32'd7, lat);
    check("postrst_latency", lat, 32'd34);
    check("postrst_lo", lo, 32'd14);
    check("postrst_hi", hi, 32'd2);

    // Busy pulses ignored; back-to-back start in the pronto cycle accepted.
    @(negedge clock);
    a = 32'd100; b = 32'd7; comeco = 1'b1;
    @(posedge clock); #1;
    comeco = 1'b0;
    npr = 0;
    pr_edge[0] = -1;
    pr_edge[1] = -1;
    lo2 = '0;
    hi2 = '0;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clock); #1;
      if (e == 4 || e == 19) comeco = 1'b1;
      if (e == 5 || e == 20 || e == 35) comeco = 1'b0;
      if (pronto) begin
        if (npr < 2) pr_edge[npr] = e;
        npr++;
        if (npr == 1) begin
          check("busy_first_lo", lo, 32'd14);
          check("busy_first_hi", hi, 32'd2);
          a = 32'h1234_5678; b = 32'h0000_0100; comeco = 1'b1;
        end else begin
          lo2 = lo;
          hi2 = hi;
        end
      end
    end
    check("busy_pronto_count", npr, 32'd2);
    check("busy_first_edge", pr_edge[0], 32'd34);
    check("b2b_second_edge", pr_edge[1], 32'd69);
    check("b2b_lo", lo2, 32'h0012_3456);
    check("b2b_hi", hi2, 32'h0000_0078);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_unit
